// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the fetch stage: widths, reset/halt defaults,
// the fetch state enum and a PC alignment helper.
package fetch_stage_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC_DEF   = '0;
  localparam logic [INSTR_W-1:0] ECALL_WORD_DEF = 32'h00000073;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & {{(PC_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// IF/ID handshake bundle between fetch (master) and decode (slave).
// valid/ready: a transfer happens on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the master keeps
// out_pc/out_instr stable unless a redirect flushes the entry.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (output out_valid, output out_pc, output out_instr, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_instr, output out_ready);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID holding register: flush beats load, otherwise contents hold.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      instr <= in_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/DRAIN/HALT control and accept counter,
// feeding decode through the IF/ID holding register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC   = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] ECALL_WORD = ECALL_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  fetch_stage_if.master      dec,
  output logic               halted,
  output logic [31:0]        fetch_count,
  output fetch_state_e       dbg_state
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            handshake;
  logic            redirect;
  logic            advance;
  logic            flush;

  assign handshake = dec.out_valid & dec.out_ready;
  // HALT is terminal, so a redirect there must not disturb anything.
  assign redirect  = redirect_valid & (state_q != ST_HALT);
  assign advance   = (state_q == ST_RUN) & ~redirect_valid &
                     (~dec.out_valid | dec.out_ready);
  assign flush     = redirect | (handshake & (state_q != ST_RUN));

  assign imem_addr = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      state_d = ST_RUN;
      pc_d    = align_pc(redirect_pc);
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (advance) begin
            pc_d = pc_q + PC_W'(4);
            if (imem_instr == ECALL_WORD) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: if (handshake) state_d = ST_HALT;
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (handshake) fetch_count <= fetch_count + 32'd1;
    end
  end

  ifid_reg u_ifid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (advance),
    .flush    (flush),
    .in_pc    (pc_q),
    .in_instr (imem_instr),
    .valid    (dec.out_valid),
    .pc       (dec.out_pc),
    .instr    (dec.out_instr)
  );

endmodule
